// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_pkg : word type, reset PC and fetch entry shared by stages  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package pipeline_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = '0;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prefetch_fifo : synchronous FIFO of fetch entries with flush         |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module prefetch_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output fetch_entry_t             o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && (r_count != c_full);

  // Storage is cleared on reset so the head reads zero before the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_prefetch_queue : fetch PC, request throttle and redirect flush |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module fetch_prefetch_queue
  import pipeline_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_redirect_valid,
  input  word_t i_redirect_pc,
  output logic  o_imem_req,
  output word_t o_imem_addr,
  input  logic  i_imem_rvalid,
  input  word_t i_imem_rdata,
  output logic  o_instr_valid,
  output word_t o_instr,
  output word_t o_instr_pc,
  input  logic  i_decode_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] c_cap = (CW+1)'(DEPTH);

  word_t         r_fetch_pc;
  word_t         r_live_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic [CW-1:0] w_count;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic [CW:0]   w_live;
  logic          w_req;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;

  // Requests owed to the discard counter never land in the queue, so they
  // do not count against its capacity.
  assign w_live = {1'b0, w_count} + {1'b0, r_outstanding} - {1'b0, r_discard};

  assign w_req  = rst_n && !i_redirect_valid && (w_live < c_cap);
  assign w_drop = i_imem_rvalid && (r_discard != '0);
  assign w_push = i_imem_rvalid && (r_discard == '0) && !i_redirect_valid;
  assign w_pop  = !w_empty && i_decode_ready && !i_redirect_valid;

  assign w_push_data.pc    = r_live_pc;
  assign w_push_data.instr = i_imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_live_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc    <= i_redirect_pc;
      r_live_pc     <= i_redirect_pc;
      r_outstanding <= r_outstanding - CW'(i_imem_rvalid);
      r_discard     <= r_outstanding - CW'(i_imem_rvalid);
    end else begin
      if (w_req) begin
        r_fetch_pc <= r_fetch_pc + word_t'(1);
      end
      if (w_push) begin
        r_live_pc <= r_live_pc + word_t'(1);
      end
      r_outstanding <= r_outstanding + CW'(w_req) - CW'(i_imem_rvalid);
      if (w_drop) begin
        r_discard <= r_discard - CW'(1);
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (i_redirect_valid),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_fetch_pc;
  assign o_instr_valid = !w_empty;
  assign o_instr       = w_head.instr;
  assign o_instr_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_prefetch_queue : directed bench with fixed-latency memory   |
// | Revision                : 1.0                                        |
// +----------------------------------------------------------------------+
module tb_fetch_prefetch_queue;
  import pipeline_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  redirect_valid = 1'b0;
  word_t redirect_pc = '0;
  logic  imem_req;
  word_t imem_addr;
  logic  imem_rvalid = 1'b0;
  word_t imem_rdata = '0;
  logic  instr_valid;
  word_t instr;
  word_t instr_pc;
  logic  decode_ready = 1'b1;

  int n_pass = 0;
  int n_total = 0;
  int lat = 1;

  word_t log_pc[$];
  word_t log_in[$];

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_rvalid    (imem_rvalid),
    .i_imem_rdata     (imem_rdata),
    .o_instr_valid    (instr_valid),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
    .i_decode_ready   (decode_ready)
  );

  // Fixed-latency memory: a request seen at an edge answers lat cycles later.
  logic  d_v [8];
  word_t d_a [8];
  always @(posedge clk) begin
    logic  ov;
    word_t oa;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        d_v[i] = 1'b0;
        d_a[i] = '0;
      end
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      if (lat == 1) begin
        ov = imem_req;
        oa = imem_addr;
      end else begin
        ov = d_v[0];
        oa = d_a[0];
      end
      for (int i = 0; i < 7; i++) begin
        d_v[i] = d_v[i+1];
        d_a[i] = d_a[i+1];
      end
      d_v[7] = 1'b0;
      if (lat >= 2) begin
        d_v[lat-2] = imem_req;
        d_a[lat-2] = imem_addr;
      end
      imem_rvalid <= ov;
      imem_rdata  <= 32'hA000_0000 + oa;
    end
  end

  always @(posedge clk) begin
    if (rst_n && instr_valid && decode_ready && !redirect_valid) begin
      log_pc.push_back(instr_pc);
      log_in.push_back(instr);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench in cycle 0 (first cycle with reset released).
  task automatic do_reset(input int l, input logic rdy);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    decode_ready = rdy;
    lat = l;
    tick(3);
    log_pc.delete();
    log_in.delete();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    decode_ready = 1'b1;
    lat = 1;
    tick(3);
    n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h expected 00000000", imem_addr); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid); else n_pass++;
    n_total++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h expected 00000000", instr); else n_pass++;
    n_total++; if (instr_pc !== 32'h0) $display("FAIL reset_pc: got %h expected 00000000", instr_pc); else n_pass++;
  endtask

  task automatic test_stream;
    do_reset(1, 1'b1);
    n_total++; if (imem_req !== 1'b1) $display("FAIL stream_first_req: got %b expected 1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL stream_first_addr: got %h expected 00000000", imem_addr); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b0) $display("FAIL stream_c1_valid: got %b expected 0", instr_valid); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b1) $display("FAIL stream_c2_valid: got %b expected 1", instr_valid); else n_pass++;
    n_total++; if (instr_pc !== 32'h0) $display("FAIL stream_c2_pc: got %h expected 00000000", instr_pc); else n_pass++;
    n_total++; if (instr !== 32'hA000_0000) $display("FAIL stream_c2_instr: got %h expected a0000000", instr); else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'(k)) $display("FAIL stream_pc[%0d]: got v=%b %h expected v=1 %h", k, instr_valid, instr_pc, 32'(k)); else n_pass++;
      n_total++; if (instr !== 32'hA000_0000 + 32'(k)) $display("FAIL stream_instr[%0d]: got %h expected %h", k, instr, 32'hA000_0000 + 32'(k)); else n_pass++;
      n_total++; if (imem_addr !== 32'(k + 2)) $display("FAIL stream_addr[%0d]: got %h expected %h", k, imem_addr, 32'(k + 2)); else n_pass++;
    end
  endtask

  task automatic test_stall;
    do_reset(1, 1'b0);
    tick(4);
    n_total++; if (imem_req !== 1'b0) $display("FAIL stall_req_c4: got %b expected 0", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'd4) $display("FAIL stall_addr_c4: got %h expected 00000004", imem_addr); else n_pass++;
    tick(6);
    n_total++; if (instr_valid !== 1'b1) $display("FAIL stall_valid: got %b expected 1", instr_valid); else n_pass++;
    n_total++; if (instr_pc !== 32'h0) $display("FAIL stall_head_pc: got %h expected 00000000", instr_pc); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL stall_req_c10: got %b expected 0", imem_req); else n_pass++;
    decode_ready = 1'b1;
    tick(16);
    n_total++; if (log_pc.size() < 8) $display("FAIL stall_drain_count: got %0d expected >=8", log_pc.size()); else n_pass++;
    for (int i = 0; i < 8 && i < log_pc.size(); i++) begin
      n_total++; if (log_pc[i] !== 32'(i) || log_in[i] !== 32'hA000_0000 + 32'(i)) $display("FAIL stall_seq[%0d]: got %h/%h expected %h/%h", i, log_pc[i], log_in[i], 32'(i), 32'hA000_0000 + 32'(i)); else n_pass++;
    end
  endtask

  task automatic test_redirect_inflight;
    do_reset(2, 1'b1);
    tick(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rdi_req_in_redirect: got %b expected 0", imem_req); else n_pass++;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL rdi_target_req: got %b %h expected 1 00000040", imem_req, imem_addr); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL rdi_valid_c3: got %b expected 0", instr_valid); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b0) $display("FAIL rdi_valid_c4: got %b expected 0", instr_valid); else n_pass++;
    n_total++; if (imem_addr !== 32'h41) $display("FAIL rdi_addr_c4: got %h expected 00000041", imem_addr); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b0) $display("FAIL rdi_valid_c5: got %b expected 0", instr_valid); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'hA000_0040) $display("FAIL rdi_head0: got v=%b %h/%h expected v=1 00000040/a0000040", instr_valid, instr_pc, instr); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h41) $display("FAIL rdi_head1: got v=%b %h expected v=1 00000041", instr_valid, instr_pc); else n_pass++;
  endtask

  task automatic test_redirect_pop;
    do_reset(2, 1'b1);
    tick(4);
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1 || imem_rvalid !== 1'b1) $display("FAIL rdp_setup: got v=%b pc=%h rv=%b expected v=1 pc=00000001 rv=1", instr_valid, instr_pc, imem_rvalid); else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL rdp_empty_c5: got %b expected 0", instr_valid); else n_pass++;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) $display("FAIL rdp_target_req: got %b %h expected 1 00000080", imem_req, imem_addr); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b0) $display("FAIL rdp_valid_c6: got %b expected 0", instr_valid); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b0) $display("FAIL rdp_valid_c7: got %b expected 0", instr_valid); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h80) $display("FAIL rdp_head_c8: got v=%b %h expected v=1 00000080", instr_valid, instr_pc); else n_pass++;
    tick(2);
    n_total++; if (log_pc.size() != 3) $display("FAIL rdp_log_size: got %0d expected 3", log_pc.size()); else n_pass++;
    if (log_pc.size() >= 3) begin
      n_total++; if (log_pc[0] !== 32'h0 || log_pc[1] !== 32'h80 || log_pc[2] !== 32'h81) $display("FAIL rdp_log_seq: got %h %h %h expected 00000000 00000080 00000081", log_pc[0], log_pc[1], log_pc[2]); else n_pass++;
    end
  endtask

  task automatic test_wrap;
    do_reset(1, 1'b1);
    tick(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (imem_addr !== 32'hFFFF_FFFF || instr_valid !== 1'b0) $display("FAIL wrap_t1: got %h v=%b expected ffffffff v=0", imem_addr, instr_valid); else n_pass++;
    tick();
    n_total++; if (imem_addr !== 32'h0 || instr_valid !== 1'b0) $display("FAIL wrap_t2: got %h v=%b expected 00000000 v=0", imem_addr, instr_valid); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFF || instr !== 32'h9FFF_FFFF) $display("FAIL wrap_t3: got v=%b %h/%h expected v=1 ffffffff/9fffffff", instr_valid, instr_pc, instr); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hA000_0000) $display("FAIL wrap_t4: got v=%b %h/%h expected v=1 00000000/a0000000", instr_valid, instr_pc, instr); else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset(1, 1'b0);
    tick(8);
    n_total++; if (instr_valid !== 1'b1 || imem_addr !== 32'd4) $display("FAIL rstm_full: got v=%b addr=%h expected v=1 addr=00000004", instr_valid, imem_addr); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL rstm_async: got v=%b req=%b expected v=0 req=0", instr_valid, imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0 || instr_pc !== 32'h0) $display("FAIL rstm_clear: got addr=%h pc=%h expected 00000000 00000000", imem_addr, instr_pc); else n_pass++;
    tick(2);
    decode_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rstm_restart: got %b %h expected 1 00000000", imem_req, imem_addr); else n_pass++;
    tick(2);
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hA000_0000) $display("FAIL rstm_first: got v=%b %h/%h expected v=1 00000000/a0000000", instr_valid, instr_pc, instr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction prefetch stage between the instruction memory port and the IF/ID segment register of the pipelined processor. It owns the fetch PC, keeps up to DEPTH instruction requests outstanding or buffered, and presents one instruction-plus-PC at a time to decode under a valid/ready handshake. A taken jump from the EX-stage jump unit arrives as a redirect: it flushes the queue and discards every in-flight memory response.

## Interface
- XLEN, 32, instruction and address width.
- DEPTH, 4, queue entries; also the cap on buffered plus in-flight requests; power of two, ≥2.
- RESET_PC, 32'd0, first fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; low clears all state.
- redirect_valid  in  1  taken jump (PCSource) this cycle.
- redirect_pc  in  XLEN  jump target (pc_plus_inm).
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  XLEN  word address of the request.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  XLEN  instruction word.
- instr_valid  out  1  queue head valid.
- instr  out  XLEN  head instruction.
- instr_pc  out  XLEN  PC of the head instruction.
- decode_ready  in  1  IF/ID accepts the head (low = stall).

## Operation
- State:
  - fetch_pc (XLEN).
  - Queue storage of {pc, instr}, with read pointer, write pointer and count.
  - outstanding: number of requests issued and not yet answered.
  - discard_cnt: number of pending responses to drop.
  - All counters are $clog2(DEPTH)+1 bits.
- Request: imem_req = rst && !redirect_valid && (count + outstanding − discard_cnt) < DEPTH. imem_addr = fetch_pc.
- On each issued request, fetch_pc increments by 1 (word addressing) and wraps modulo 2^XLEN.
- Response handling:
  - If discard_cnt > 0, the response is dropped and discard_cnt decrements.
  - Otherwise {pc, rdata} is pushed. The pc is the address of the oldest live request, tracked by a live_pc register that increments on each push.
- Pop: when instr_valid && decode_ready, the read pointer advances.
- Simultaneous push and pop: count is unchanged. A push into an empty queue with a pop in the same cycle is legal; the head is only presented from the next cycle.
- Redirect has priority over all other events in its cycle:
  - The queue is cleared and no pop is counted.
  - fetch_pc and live_pc load redirect_pc.
  - discard_cnt takes all responses still owed, minus one if a response arrives in this cycle (that response is dropped).
  - No request is issued in the redirect cycle.
- Overflow is impossible by the request rule. No memory back-pressure exists.
- Reset mid-operation clears the queue, outstanding and discard_cnt immediately. Responses arriving after reset release that belong to pre-reset requests are outside the contract; memory is reset alongside.

## Timing
- Reset values:
  - imem_req = 0.
  - imem_addr = RESET_PC.
  - instr_valid = 0.
  - instr = 0.
  - instr_pc = 0.
- First request is issued in the first cycle with rst high, at RESET_PC.
- Memory latency L (fixed, ≥1): a request in cycle t gives rvalid in cycle t+L. The pushed entry is visible on instr_valid at t+L+1.
- Redirect in cycle T with L=1:
  - Request to the target in T+1.
  - Response in T+2.
  - instr_valid with instr_pc = target in T+3.
- Steady state with decode_ready high and L=1: one instruction per cycle once DEPTH ≥ 2.
- All outputs except imem_req come directly from registers or the queue head.

## Structure
- Shared package pipeline_pkg: XLEN, word_t (logic [XLEN−1:0]), RESET_PC default and a fetch_entry_t struct {pc, instr}. The ID, EX and WB stages reuse word_t.
- One sub-module, prefetch_fifo: a parameterised synchronous FIFO of fetch_entry_t with push, pop and flush inputs and count, empty and head outputs. All request, discard and PC logic lives in the top.

## Test plan
- Reset then run, L=1, decode_ready=1, memory returns instr = 0xA0000000+addr → instr_pc sequence 0,1,2,… with matching instr; first instr_valid two cycles after reset release.
- decode_ready held low for 10 cycles → instr_valid stays high on pc 0; imem_req drops once count+outstanding = 4; no entry is lost or duplicated after release.
- Redirect to 0x40 with 2 requests in flight (L=2) → both stale responses are dropped; next presented instr_pc is 0x40, then 0x41.
- Redirect in the same cycle as a pop and a response → queue is empty the next cycle; the arriving response is dropped; discard_cnt counts the remainder.
- fetch_pc at 0xFFFFFFFF → next request address is 0x00000000, pc fields wrap identically.
- Assert rst low mid-stream with a full queue → instr_valid and imem_req go to 0 asynchronously; after release, fetch restarts at RESET_PC.
